dcache_req_arbiter: RTL and testbench
=====================================

DCACHE_REQ_ARBITER -- requirements
Module: dcache_req_arbiter

Interface
REQ-001 SHALL have parameter NrPorts, default 3, number of requesters (load unit, store unit, PTW).
REQ-002 SHALL have parameter AddrWidth, default 32, request address width (XLEN).
REQ-003 SHALL have parameter DataWidth, default 32, read/write data width.
REQ-004 SHALL have parameter TidWidth, default 2, cache transaction ID width; 2**TidWidth outstanding slots.
REQ-005 SHALL have ports: clk_i input 1, clock; rst_ni input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: req_valid_i input NrPorts, request valid; req_ready_o output NrPorts, request accepted.
REQ-007 SHALL have ports: req_addr_i input NrPorts*AddrWidth; req_we_i input NrPorts; req_wdata_i input NrPorts*DataWidth; port p in slice p.
REQ-008 SHALL have ports: cache_req_valid_o output 1; cache_req_ready_i input 1; cache_req_addr_o output AddrWidth; cache_req_we_o output 1; cache_req_wdata_o output DataWidth; cache_req_tid_o output TidWidth.
REQ-009 SHALL have ports: cache_rsp_valid_i input 1; cache_rsp_tid_i input TidWidth; cache_rsp_data_i input DataWidth.
REQ-010 SHALL have ports: rsp_valid_o output NrPorts; rsp_data_o output DataWidth (shared); rsp_err_o output 1, unknown-TID response pulse.

Function
REQ-011 SHALL implement FSM IDLE/ISSUE; IDLE->ISSUE when any req_valid_i set and a free TID exists; ISSUE->IDLE on cache_req_valid_o && cache_req_ready_i.
REQ-012 SHALL register the winner's addr/we/wdata, the winner index and lowest free TID on the IDLE->ISSUE edge; cache_req_* outputs driven from these registers only.
REQ-013 SHALL assert cache_req_valid_o exactly in ISSUE; payload stable until handshake; valid never withdrawn.
REQ-014 SHALL assert req_ready_o[w] for one cycle, the cycle of the IDLE->ISSUE transition, winner w only; zero for all other ports.
REQ-015 SHALL select winner round-robin: first requesting port at or after rr_ptr, wrapping NrPorts-1->0; rr_ptr <= w+1 (mod NrPorts) on cache handshake.
REQ-016 SHALL keep per-TID table {busy, owner}; set busy/owner on cache handshake; clear busy on cache_rsp_valid_i with busy TID.
REQ-017 SHALL, on response to busy TID t, assert rsp_valid_o[owner(t)] same cycle (combinational), rsp_data_o = cache_rsp_data_i.
REQ-018 SHALL, on response to non-busy TID, drive rsp_valid_o all zero and pulse rsp_err_o one cycle; table unchanged.
REQ-019 SHALL stay in IDLE while all TIDs busy (full); a TID freed by a response in cycle N is grantable no earlier than cycle N+1.
REQ-020 SHALL handle response and issue handshake in same cycle on different TIDs independently; same TID impossible (busy TIDs never issued).
REQ-021 SHALL apply writes identically to reads: every issued request consumes a TID and expects one response.
REQ-022 SHALL have request-to-cache latency of 1 cycle: req accepted cycle N, cache_req_valid_o first high cycle N+1.

Reset
REQ-023 SHALL on rst_ni low asynchronously force: state IDLE, rr_ptr 0, all TID busy 0, req_ready_o 0, cache_req_valid_o 0, cache_req_addr_o/we/wdata/tid 0, rsp_valid_o 0, rsp_err_o 0.
REQ-024 SHALL discard an in-flight ISSUE request and all outstanding TIDs on reset mid-operation; responses arriving after reset release report rsp_err_o.

Configuration
REQ-025 SHALL support macro DCACHE_ARB_FIXED_PRIO_EN: defined -> fixed priority, lowest port index wins, rr_ptr absent; undefined -> round-robin per REQ-015.

Verification
REQ-026 SHALL cover: ports 0,1,2 request continuously, ready_i=1, responses immediate -> grants 0,1,2,0,1,2; TIDs 0,1,2,3,0...
REQ-027 SHALL cover: 4 issues, no responses -> 5th request stalls in IDLE; response TID 2 cycle N -> TID 2 reissued, cache_req_valid_o high cycle N+2.
REQ-028 SHALL cover: cache_req_ready_i low 5 cycles in ISSUE -> addr/we/wdata/tid held constant, no req_ready_o pulse.
REQ-029 SHALL cover: response TID 3 with none outstanding -> rsp_err_o 1 one cycle, rsp_valid_o 3'b000.
REQ-030 SHALL cover: rst_ni low during ISSUE with 2 TIDs busy -> all outputs 0 immediately; after release, request from port 1 issues with TID 0.
REQ-031 SHALL cover: DCACHE_ARB_FIXED_PRIO_EN defined, ports 0 and 2 requesting continuously -> port 0 always wins, port 2 starves.

Source files
------------

// File: rtl/dcache_req_arbiter.sv
// Data-cache request arbiter: N requesters -> one cache port, TID-tagged responses.
// Define DCACHE_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest) instead of round-robin.
module dcache_req_arbiter #(
  parameter int unsigned NrPorts   = 3,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned TidWidth  = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NrPorts-1:0]             req_valid_i,
  output logic [NrPorts-1:0]             req_ready_o,
  input  logic [NrPorts*AddrWidth-1:0]   req_addr_i,
  input  logic [NrPorts-1:0]             req_we_i,
  input  logic [NrPorts*DataWidth-1:0]   req_wdata_i,
  output logic                           cache_req_valid_o,
  input  logic                           cache_req_ready_i,
  output logic [AddrWidth-1:0]           cache_req_addr_o,
  output logic                           cache_req_we_o,
  output logic [DataWidth-1:0]           cache_req_wdata_o,
  output logic [TidWidth-1:0]            cache_req_tid_o,
  input  logic                           cache_rsp_valid_i,
  input  logic [TidWidth-1:0]            cache_rsp_tid_i,
  input  logic [DataWidth-1:0]           cache_rsp_data_i,
  output logic [NrPorts-1:0]             rsp_valid_o,
  output logic [DataWidth-1:0]           rsp_data_o,
  output logic                           rsp_err_o
);

  localparam int unsigned NrTids = 2 ** TidWidth;
  localparam int unsigned PortW  = (NrPorts > 1) ? $clog2(NrPorts) : 1;

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e             state_q;
  logic [NrTids-1:0]  busy_q;
  logic [PortW-1:0]   owner_q [NrTids];
  logic [PortW-1:0]   win_q;

  logic               any_req;
  logic [PortW-1:0]   win_idx;
  logic               tid_free;
  logic [TidWidth-1:0] free_tid;
  logic               grant;
  logic               hs;
  logic               rsp_hit;
  logic [PortW-1:0]   rsp_owner;

`ifdef DCACHE_ARB_FIXED_PRIO_EN
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    for (int i = NrPorts - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        any_req = 1'b1;
        win_idx = PortW'(i);
      end
    end
  end
`else
  logic [PortW-1:0] rr_q;

  // Scan from the farthest offset down so the closest port to rr_q wins.
  always_comb begin
    int idx;
    any_req = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int i = NrPorts - 1; i >= 0; i--) begin
      idx = (int'(rr_q) + i) % int'(NrPorts);
      if (req_valid_i[idx]) begin
        any_req = 1'b1;
        win_idx = PortW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= '0;
    end else if (hs) begin
      if (win_q == PortW'(NrPorts - 1)) begin
        rr_q <= '0;
      end else begin
        rr_q <= win_q + PortW'(1);
      end
    end
  end
`endif

  always_comb begin
    tid_free = 1'b0;
    free_tid = '0;
    for (int t = NrTids - 1; t >= 0; t--) begin
      if (!busy_q[t]) begin
        tid_free = 1'b1;
        free_tid = TidWidth'(t);
      end
    end
  end

  assign grant = rst_ni && (state_q == IDLE)
               && any_req && tid_free;
  assign hs    = cache_req_valid_o && cache_req_ready_i;

  always_comb begin
    req_ready_o = '0;
    for (int p = 0; p < NrPorts; p++) begin
      req_ready_o[p] = grant && (win_idx == PortW'(p));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= IDLE;
      cache_req_valid_o <= 1'b0;
      cache_req_addr_o  <= '0;
      cache_req_we_o    <= 1'b0;
      cache_req_wdata_o <= '0;
      cache_req_tid_o   <= '0;
      win_q             <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q           <= ISSUE;
            cache_req_valid_o <= 1'b1;
            cache_req_addr_o  <=
              req_addr_i[int'(win_idx)*AddrWidth +: AddrWidth];
            cache_req_we_o    <= req_we_i[win_idx];
            cache_req_wdata_o <=
              req_wdata_i[int'(win_idx)*DataWidth +: DataWidth];
            cache_req_tid_o   <= free_tid;
            win_q             <= win_idx;
          end
        end
        ISSUE: begin
          if (cache_req_ready_i) begin
            state_q           <= IDLE;
            cache_req_valid_o <= 1'b0;
          end
        end
      endcase
    end
  end

  assign rsp_owner = owner_q[cache_rsp_tid_i];
  assign rsp_hit   = rst_ni && cache_rsp_valid_i
                   && busy_q[cache_rsp_tid_i];
  assign rsp_err_o = rst_ni && cache_rsp_valid_i
                   && !busy_q[cache_rsp_tid_i];
  assign rsp_data_o = cache_rsp_data_i;

  always_comb begin
    rsp_valid_o = '0;
    for (int p = 0; p < NrPorts; p++) begin
      rsp_valid_o[p] = rsp_hit && (rsp_owner == PortW'(p));
    end
  end

  // Issue and response never target the same TID, so both may update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int t = 0; t < NrTids; t++) begin
        owner_q[t] <= '0;
      end
    end else begin
      if (hs) begin
        busy_q[cache_req_tid_o]  <= 1'b1;
        owner_q[cache_req_tid_o] <= win_q;
      end
      if (rsp_hit) begin
        busy_q[cache_rsp_tid_i] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Testbench for dcache_req_arbiter: grant tables plus scoreboarded responses.
// Build with DCACHE_ARB_FIXED_PRIO_EN to exercise the fixed-priority variant.
module tb_dcache_req_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [2:0]  req_valid_i;
  logic [2:0]  req_ready_o;
  logic [95:0] req_addr_i;
  logic [2:0]  req_we_i;
  logic [95:0] req_wdata_i;
  logic        cache_req_valid_o;
  logic        cache_req_ready_i;
  logic [31:0] cache_req_addr_o;
  logic        cache_req_we_o;
  logic [31:0] cache_req_wdata_o;
  logic [1:0]  cache_req_tid_o;
  logic        cache_rsp_valid_i;
  logic [1:0]  cache_rsp_tid_i;
  logic [31:0] cache_rsp_data_i;
  logic [2:0]  rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic        rsp_err_o;

  dcache_req_arbiter dut (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .req_valid_i       (req_valid_i),
    .req_ready_o       (req_ready_o),
    .req_addr_i        (req_addr_i),
    .req_we_i          (req_we_i),
    .req_wdata_i       (req_wdata_i),
    .cache_req_valid_o (cache_req_valid_o),
    .cache_req_ready_i (cache_req_ready_i),
    .cache_req_addr_o  (cache_req_addr_o),
    .cache_req_we_o    (cache_req_we_o),
    .cache_req_wdata_o (cache_req_wdata_o),
    .cache_req_tid_o   (cache_req_tid_o),
    .cache_rsp_valid_i (cache_rsp_valid_i),
    .cache_rsp_tid_i   (cache_rsp_tid_i),
    .cache_rsp_data_i  (cache_rsp_data_i),
    .rsp_valid_o       (rsp_valid_o),
    .rsp_data_o        (rsp_data_o),
    .rsp_err_o         (rsp_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         port;
    logic [1:0] tid;
  } vec_t;

  typedef struct {
    logic [1:0] tid;
    int         owner;
  } ent_t;

  vec_t        tab [8];
  ent_t        sb [$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] rsp_data_exp;

  function automatic logic [31:0] addr_of(int p);
    return 32'h8000_0000 | (32'(p) << 8);
  endfunction

  function automatic logic [31:0] wdata_of(int p);
    return 32'hD00D_0000 | 32'(p);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic rsp_drive(logic [1:0] tid);
    rsp_data_exp      = $urandom;
    cache_rsp_valid_i = 1'b1;
    cache_rsp_tid_i   = tid;
    cache_rsp_data_i  = rsp_data_exp;
  endtask

  task automatic rsp_check();
    int k;
    k = -1;
    foreach (sb[i]) if (sb[i].tid == cache_rsp_tid_i) k = i;
    if (k >= 0) begin
      chk("rsp_valid", 64'(rsp_valid_o), 64'(1) << sb[k].owner);
      chk("rsp_data", 64'(rsp_data_o), 64'(rsp_data_exp));
      chk("rsp_err_clear", 64'(rsp_err_o), 0);
      sb.delete(k);
    end else begin
      chk("rsp_valid_none", 64'(rsp_valid_o), 0);
      chk("rsp_err", 64'(rsp_err_o), 1);
    end
  endtask

  task automatic drain();
    for (int c = 0; c < 16 && sb.size() > 0; c++) begin
      rsp_drive(sb[0].tid);
      #1;
      rsp_check();
      @(negedge clk_i);
    end
    cache_rsp_valid_i = 1'b0;
    chk("drain_empty", 64'(sb.size()), 0);
  endtask

  task automatic issue_one(int port, logic [1:0] exp_tid);
    bit got;
    got               = 1'b0;
    req_valid_i       = 3'(1 << port);
    cache_req_ready_i = 1'b1;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (req_ready_o != 0) got = 1'b1;
      else @(negedge clk_i);
    end
    if (!got) begin
      chk("grant_timeout", 0, 1);
      req_valid_i = '0;
      return;
    end
    chk("grant", 64'(req_ready_o), 64'(1 << port));
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    chk("issue_valid", 64'(cache_req_valid_o), 1);
    chk("issue_addr", 64'(cache_req_addr_o), 64'(addr_of(port)));
    chk("issue_we", 64'(cache_req_we_o), 64'(req_we_i[port]));
    chk("issue_wdata", 64'(cache_req_wdata_o), 64'(wdata_of(port)));
    chk("issue_tid", 64'(cache_req_tid_o), 64'(exp_tid));
    sb.push_back('{exp_tid, port});
    @(negedge clk_i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int g;
    int h;
    bit ok;

    tab[0] = '{0, 2'd0};
    tab[1] = '{1, 2'd1};
    tab[2] = '{2, 2'd2};
    tab[3] = '{0, 2'd3};
    tab[4] = '{1, 2'd0};
    tab[5] = '{2, 2'd1};
    tab[6] = '{0, 2'd2};
    tab[7] = '{1, 2'd3};

    rst_ni            = 1'b0;
    req_valid_i       = 3'b111;
    cache_req_ready_i = 1'b0;
    cache_rsp_valid_i = 1'b0;
    cache_rsp_tid_i   = '0;
    cache_rsp_data_i  = '0;
    req_we_i          = 3'b010;
    for (int p = 0; p < 3; p++) begin
      req_addr_i[p*32 +: 32]  = addr_of(p);
      req_wdata_i[p*32 +: 32] = wdata_of(p);
    end

    @(negedge clk_i);
    #1;
    chk("rst_ready", 64'(req_ready_o), 0);
    chk("rst_cvalid", 64'(cache_req_valid_o), 0);
    chk("rst_addr", 64'(cache_req_addr_o), 0);
    chk("rst_tid", 64'(cache_req_tid_o), 0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 0);
    chk("rst_rsp_err", 64'(rsp_err_o), 0);
    @(negedge clk_i);
    req_valid_i = '0;
    rst_ni      = 1'b1;
    @(negedge clk_i);

`ifdef DCACHE_ARB_FIXED_PRIO_EN
    req_valid_i       = 3'b101;
    cache_req_ready_i = 1'b1;
    g                 = 0;
    for (int c = 0; c < 100 && g < 6; c++) begin
      if (sb.size() > 0) rsp_drive(sb[0].tid);
      else cache_rsp_valid_i = 1'b0;
      #1;
      if (cache_rsp_valid_i) rsp_check();
      if (req_ready_o != 0) begin
        chk("fixed_grant", 64'(req_ready_o), 3'b001);
        g++;
      end
      if (cache_req_valid_o) begin
        chk("fixed_addr", 64'(cache_req_addr_o), 64'(addr_of(0)));
        sb.push_back('{cache_req_tid_o, 0});
      end
      @(negedge clk_i);
    end
    chk("fixed_grants", 64'(g), 6);
    req_valid_i = '0;
    @(negedge clk_i);
    #1;
    if (cache_req_valid_o) sb.push_back('{cache_req_tid_o, 0});
    @(negedge clk_i);
    drain();
`else
    req_valid_i       = 3'b111;
    cache_req_ready_i = 1'b1;
    g                 = 0;
    h                 = 0;
    for (int c = 0; c < 200 && h < 8; c++) begin
      if (sb.size() == 3) rsp_drive(sb[0].tid);
      else cache_rsp_valid_i = 1'b0;
      #1;
      if (cache_rsp_valid_i) rsp_check();
      if (req_ready_o != 0 && g < 8) begin
        chk("rr_grant", 64'(req_ready_o), 64'(1 << tab[g].port));
        g++;
      end
      if (cache_req_valid_o) begin
        chk("rr_addr", 64'(cache_req_addr_o),
            64'(addr_of(tab[h].port)));
        chk("rr_tid", 64'(cache_req_tid_o), 64'(tab[h].tid));
        sb.push_back('{tab[h].tid, tab[h].port});
        h++;
      end
      @(negedge clk_i);
    end
    chk("rr_done", 64'(h), 8);
    req_valid_i       = '0;
    cache_rsp_valid_i = 1'b0;
    drain();
`endif

    // Fill all four TIDs, then stall until TID 2 comes back.
    issue_one(0, 2'd0);
    issue_one(0, 2'd1);
    issue_one(0, 2'd2);
    issue_one(0, 2'd3);
    req_valid_i = 3'b001;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("full_no_grant", 64'(req_ready_o), 0);
      chk("full_no_issue", 64'(cache_req_valid_o), 0);
      @(negedge clk_i);
    end
    rsp_drive(2'd2);
    #1;
    rsp_check();
    chk("free_same_cycle", 64'(req_ready_o), 0);
    @(negedge clk_i);
    cache_rsp_valid_i = 1'b0;
    #1;
    chk("free_grant_n1", 64'(req_ready_o), 3'b001);
    chk("free_cvalid_n1", 64'(cache_req_valid_o), 0);
    @(negedge clk_i);
    req_valid_i = '0;
    #1;
    chk("free_cvalid_n2", 64'(cache_req_valid_o), 1);
    chk("free_tid", 64'(cache_req_tid_o), 2);
    sb.push_back('{2'd2, 0});
    @(negedge clk_i);
    drain();

    // Back-pressure: payload must hold while the cache is not ready.
    req_valid_i       = 3'b010;
    cache_req_ready_i = 1'b0;
    #1;
    chk("bp_grant", 64'(req_ready_o), 3'b010);
    @(negedge clk_i);
    req_addr_i[32 +: 32]  = 32'hDEAD_BEE0;
    req_wdata_i[32 +: 32] = 32'h1234_5678;
    ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      if (cache_req_valid_o !== 1'b1) ok = 1'b0;
      if (cache_req_addr_o !== addr_of(1)) ok = 1'b0;
      if (cache_req_we_o !== 1'b1) ok = 1'b0;
      if (cache_req_wdata_o !== wdata_of(1)) ok = 1'b0;
      if (cache_req_tid_o !== 2'd0) ok = 1'b0;
      chk("bp_no_ready", 64'(req_ready_o), 0);
      @(negedge clk_i);
    end
    chk("bp_hold", 64'(ok), 1);
    req_valid_i       = '0;
    cache_req_ready_i = 1'b1;
    req_addr_i[32 +: 32]  = addr_of(1);
    req_wdata_i[32 +: 32] = wdata_of(1);
    #1;
    chk("bp_valid_hs", 64'(cache_req_valid_o), 1);
    sb.push_back('{2'd0, 1});
    @(negedge clk_i);
    #1;
    chk("bp_idle", 64'(cache_req_valid_o), 0);
    @(negedge clk_i);
    drain();

    // Response to an idle TID.
    rsp_drive(2'd3);
    #1;
    rsp_check();
    @(negedge clk_i);
    cache_rsp_valid_i = 1'b0;
    #1;
    chk("err_pulse_end", 64'(rsp_err_o), 0);
    @(negedge clk_i);

    // Reset in the middle of an issue with two TIDs outstanding.
    issue_one(0, 2'd0);
    issue_one(1, 2'd1);
    req_valid_i       = 3'b100;
    cache_req_ready_i = 1'b0;
    #1;
    chk("mid_grant", 64'(req_ready_o), 3'b100);
    @(negedge clk_i);
    #1;
    chk("mid_issue", 64'(cache_req_valid_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_cvalid", 64'(cache_req_valid_o), 0);
    chk("mid_rst_addr", 64'(cache_req_addr_o), 0);
    chk("mid_rst_we", 64'(cache_req_we_o), 0);
    chk("mid_rst_wdata", 64'(cache_req_wdata_o), 0);
    chk("mid_rst_tid", 64'(cache_req_tid_o), 0);
    chk("mid_rst_ready", 64'(req_ready_o), 0);
    chk("mid_rst_rsp", 64'(rsp_valid_o), 0);
    @(negedge clk_i);
    req_valid_i = '0;
    rst_ni      = 1'b1;
    sb.delete();
    @(negedge clk_i);
    rsp_drive(2'd1);
    #1;
    rsp_check();
    @(negedge clk_i);
    cache_rsp_valid_i = 1'b0;
    issue_one(1, 2'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
